rr_reg_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared WIDTH-bit storage register (a bank of D flip-flops).
- Up to NREQ requesters compete to load the register. The block grants one requester at a time, captures that requester's data on a clock edge, and reports which requester owns the current value.
- Sits between requester logic and the shared register bank. The register bank is internal to this block.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 34 +++
 rtl/rr_reg_arbiter.sv | 159 +++++++++++++++
 tb/tb_rr_reg_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin register arbiter.
//   state_t   : FSM encoding (IDLE, GRANT, COMMIT)
//   NREQ_DEF  : default number of requesters
//   WIDTH_DEF : default width of the shared register / data words
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority first-set-bit finder.
// Searches req starting at index ptr, then ptr+1, ... wrapping modulo NREQ,
// and returns the first index whose request bit is set.
// Ports:
//   req   in  [NREQ-1:0]  request vector
//   ptr   in  [IDW-1:0]   highest-priority index
//   valid out             at least one request bit is set
//   idx   out [IDW-1:0]   winning index (0 when valid is low)
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            valid,
  output logic [IDW-1:0]  idx
);

  int cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter and sequencer for one shared WIDTH-bit register.
// One requester at a time is granted, its data word is captured into the
// shared register, and the index of the writer is reported as owner.
// Optional feature macro: ARB_LOCK_EN (adds the lock input; a locked writer
// keeps top priority for as long as it keeps requesting).
// Ports:
//   clock  in   rising-edge clock
//   resetn in   asynchronous active-low reset
//   req    in   [NREQ-1:0]       request vector, held until done or abort
//   wdata  in   [NREQ*WIDTH-1:0] packed data, slice i belongs to requester i
//   clr    in   synchronous clear of the shared register
//   lock   in   (ARB_LOCK_EN only) keep priority on the committing requester
//   gnt    out  [NREQ-1:0]  registered one-hot grant
//   q      out  [WIDTH-1:0] shared register contents
//   owner  out  [IDW-1:0]   index of the requester that last wrote q
//   busy   out  high in GRANT and COMMIT
//   done   out  one-cycle pulse in COMMIT
module rr_reg_arbiter
  import arb_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  clr,
`ifdef ARB_LOCK_EN
  input  logic                  lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDW-1:0]        owner,
  output logic                  busy,
  output logic                  done
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   w_q, w_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [IDW-1:0]   owner_q, owner_d;
`ifdef ARB_LOCK_EN
  logic             locked_q, locked_d;
`endif

  logic             pick_valid;
  logic [IDW-1:0]   pick_idx;
  logic [WIDTH-1:0] wsel;
  logic [IDW-1:0]   ptr_inc;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign wsel    = wdata[int'(w_q)*WIDTH +: WIDTH];
  assign ptr_inc = (w_q == IDW'(NREQ - 1)) ? '0 : w_q + 1'b1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      w_q      <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      q_q      <= '0;
      owner_q  <= '0;
`ifdef ARB_LOCK_EN
      locked_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      q_q      <= q_d;
      owner_q  <= owner_d;
`ifdef ARB_LOCK_EN
      locked_q <= locked_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    ptr_d    = ptr_q;
    gnt_d    = '0;
    q_d      = q_q;
    owner_d  = owner_q;
`ifdef ARB_LOCK_EN
    locked_d = locked_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef ARB_LOCK_EN
        // While locked, ptr already points at the locked requester, so the
        // rotating search picks it first whenever it still requests.
        if (locked_q && !req[ptr_q]) begin
          locked_d = 1'b0;
        end
`endif
        if (pick_valid) begin
          w_d     = pick_idx;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
          state_d = GRANT;
        end
        if (clr) begin
          q_d = '0;
        end
      end

      GRANT: begin
        // clr wins over the write; ptr is left alone so the same requester
        // is favoured when it re-arbitrates.
        if (clr) begin
          q_d     = '0;
          state_d = IDLE;
        end else if (req[w_q]) begin
          q_d     = wsel;
          owner_d = w_q;
          state_d = COMMIT;
`ifdef ARB_LOCK_EN
          ptr_d    = lock ? w_q : ptr_inc;
          locked_d = lock;
`else
          ptr_d    = ptr_inc;
`endif
        end else begin
          state_d = IDLE;
        end
      end

      COMMIT: begin
        state_d = IDLE;
        if (clr) begin
          q_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt   = gnt_q;
  assign q     = q_q;
  assign owner = owner_q;
  assign busy  = (state_q == GRANT) || (state_q == COMMIT);
  assign done  = (state_q == COMMIT);

endmodule

// File: tb/tb_rr_reg_arbiter.sv
module tb_rr_reg_arbiter;

  logic        clock;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic        clr;
`ifdef ARB_LOCK_EN
  logic        lock;
`endif
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  rr_reg_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .req    (req),
    .wdata  (wdata),
    .clr    (clr),
`ifdef ARB_LOCK_EN
    .lock   (lock),
`endif
    .gnt    (gnt),
    .q      (q),
    .owner  (owner),
    .busy   (busy),
    .done   (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    req      = 4'b0000;
    wdata    = 32'h0;
    clr      = 1'b0;
`ifdef ARB_LOCK_EN
    lock     = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    resetn = 1'b1;

    // Fairness and wrap: all four requesting, order 0,1,2,3,0
    wdata = 32'h4433_2211;
    req   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fair_gnt", 32'(gnt), 32'(1) << (k % 4));
      chk("fair_busy_g", 32'(busy), 32'h1);
      chk("fair_done_g", 32'(done), 32'h0);
      step();
      chk("fair_done", 32'(done), 32'h1);
      chk("fair_owner", 32'(owner), 32'(k % 4));
      chk("fair_q", 32'(q), 32'(17 * ((k % 4) + 1)));
      chk("fair_gnt_c", 32'(gnt), 32'h0);
      step();
      chk("fair_idle_done", 32'(done), 32'h0);
      chk("fair_idle_busy", 32'(busy), 32'h0);
    end
    req = 4'b0000;

    // Single write from requester 2 (ptr is 1 here)
    wdata = 32'h003C_0000;
    req   = 4'b0100;
    step();
    chk("single_gnt", 32'(gnt), 32'h4);
    step();
    chk("single_q", 32'(q), 32'h3C);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_done", 32'(done), 32'h1);
    chk("single_gnt_c", 32'(gnt), 32'h0);
    req = 4'b0000;
    step();
    chk("single_done_off", 32'(done), 32'h0);
    chk("single_q_hold", 32'(q), 32'h3C);

    // ptr should now be 3: requesters 0 and 3 compete, 3 wins
    wdata = 32'hAA00_0055;
    req   = 4'b1001;
    step();
    chk("ptr3_gnt", 32'(gnt), 32'h8);
    step();
    chk("ptr3_q", 32'(q), 32'hAA);
    chk("ptr3_owner", 32'(owner), 32'h3);
    req = 4'b0000;
    step();

    // Abort: requester 1 drops during GRANT (ptr is 0)
    wdata = 32'h0000_7700;
    req   = 4'b0010;
    step();
    chk("abort_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_gnt_off", 32'(gnt), 32'h0);
    chk("abort_q", 32'(q), 32'hAA);
    chk("abort_owner", 32'(owner), 32'h3);
    req = 4'b0110;
    step();
    chk("abort_regnt", 32'(gnt), 32'h2);
    step();
    chk("abort_q2", 32'(q), 32'h77);
    chk("abort_owner2", 32'(owner), 32'h1);
    req = 4'b0000;
    step();

    // clr while IDLE clears q, keeps owner
    clr = 1'b1;
    step();
    chk("clr_idle_q", 32'(q), 32'h0);
    chk("clr_idle_owner", 32'(owner), 32'h1);
    clr = 1'b0;

    // clr on the GRANT->COMMIT edge suppresses the write (ptr is 2)
    wdata = 32'h00FF_0000;
    req   = 4'b0100;
    step();
    chk("clr_gnt", 32'(gnt), 32'h4);
    clr = 1'b1;
    step();
    chk("clr_q", 32'(q), 32'h0);
    chk("clr_done", 32'(done), 32'h0);
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_owner", 32'(owner), 32'h1);
    clr   = 1'b0;
    wdata = 32'h00A5_0000;
    req   = 4'b1100;
    step();
    chk("clr_regnt", 32'(gnt), 32'h4);
    step();
    chk("pre_rst_q", 32'(q), 32'hA5);
    chk("pre_rst_done", 32'(done), 32'h1);
    chk("pre_rst_owner", 32'(owner), 32'h2);

    // Asynchronous reset in the middle of COMMIT
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_owner", 32'(owner), 32'h0);
    req = 4'b0000;
    step();
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("idle_gnt", 32'(gnt), 32'h0);
      chk("idle_busy", 32'(busy), 32'h0);
    end

`ifdef ARB_LOCK_EN
    // Lock: requester 0 locks on its commit and is granted again
    wdata = 32'h0000_2211;
    req   = 4'b0011;
    lock  = 1'b1;
    step();
    chk("lock_gnt0", 32'(gnt), 32'h1);
    step();
    chk("lock_owner0", 32'(owner), 32'h0);
    step();
    step();
    chk("lock_regnt0", 32'(gnt), 32'h1);
    lock = 1'b0;
    step();
    chk("lock_owner0b", 32'(owner), 32'h0);
    step();
    step();
    chk("lock_next1", 32'(gnt), 32'h2);
    req = 4'b0000;
`else
    // After reset ptr is 0
    req = 4'b1111;
    step();
    chk("post_rst_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
